// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA timing from a 50 MHz clock with a 25 MHz pixel enable and a 2-tick colour pipeline
module vga_timing_gen #(
  parameter int H_VIS = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_VIS = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33
) (
  input  logic       clk_50MHz,
  input  logic       RESET,
  input  logic [7:0] COLOR,
  output logic       CLK_DATA,
  output logic [9:0] CURX,
  output logic [8:0] CURY,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       FRAME_TICK,
  output logic       hs_vga,
  output logic       vs_vga,
  output logic [2:0] RED,
  output logic [2:0] GREEN,
  output logic [1:0] BLUE
);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  logic       pe;
  logic [9:0] hcount, vcount, h_nxt, v_nxt;
  logic       h_last, v_last, hs_raw, vs_raw, bl_d;
  logic [1:0] hs_d, vs_d;
  assign CLK_DATA = pe;
  assign hs_vga = hs_d[1];
  assign vs_vga = vs_d[1];
  always_comb begin
    h_last = hcount >= 10'(H_TOT - 1);
    v_last = vcount >= 10'(V_TOT - 1);
    h_nxt = h_last ? '0 : hcount + 10'd1;
    v_nxt = h_last ? (v_last ? '0 : vcount + 10'd1) : vcount;
    hs_raw = !(hcount >= 10'(H_VIS + H_FP) && hcount < 10'(H_VIS + H_FP + H_SYNC));
    vs_raw = !(vcount >= 10'(V_VIS + V_FP) && vcount < 10'(V_VIS + V_FP + V_SYNC));
  end
  // Coordinates and blanking come from the next count so they stay aligned with hcount/vcount;
  // the RGB register is the second blank stage, so the gate uses the first stage here.
  always_ff @(posedge clk_50MHz or posedge RESET)
    if (RESET) begin
      pe <= 1'b0;
      hcount <= '0;
      vcount <= '0;
      CURX <= '0;
      CURY <= '0;
      HBLANK <= 1'b0;
      VBLANK <= 1'b0;
      FRAME_TICK <= 1'b0;
      hs_d <= 2'b11;
      vs_d <= 2'b11;
      bl_d <= 1'b1;
      {RED, GREEN, BLUE} <= '0;
    end else begin
      pe <= !pe;
      FRAME_TICK <= pe && h_last && v_last;
      if (pe) begin
        hcount <= h_nxt;
        vcount <= v_nxt;
        CURX <= h_nxt < 10'(H_VIS) ? h_nxt : '0;
        CURY <= v_nxt < 10'(V_VIS) ? v_nxt[8:0] : '0;
        HBLANK <= h_nxt >= 10'(H_VIS);
        VBLANK <= v_nxt >= 10'(V_VIS);
        hs_d <= {hs_d[0], hs_raw};
        vs_d <= {vs_d[0], vs_raw};
        bl_d <= HBLANK | VBLANK;
        {RED, GREEN, BLUE} <= bl_d ? '0 : COLOR;
      end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench with full horizontal geometry and a short vertical frame
module tb_vga_timing_gen;
  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int VV = 6, VF = 2, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
  typedef struct packed {
    int         n;
    logic [9:0] curx;
    logic [8:0] cury;
    logic       hb, vb, hs, vs, ft;
    logic [7:0] rgb;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] color = 8'h00;
  logic clk_data, hblank, vblank, frame_tick, hs_vga, vs_vga;
  logic [9:0] curx;
  logic [8:0] cury;
  logic [2:0] red, green;
  logic [1:0] blue;
  exp_t sb[$];
  int checks = 0, fails = 0, e = 0, cyc = 0, ft_seen = 0;
  int spot_n[8] = '{641, 642, 657, 658, 753, 754, 802, 803};
  logic spot_hs[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0] spot_rgb[8] = '{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
  always #5 clk = ~clk;
  vga_timing_gen #(.V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
    .clk_50MHz(clk), .RESET(rst), .COLOR(color), .CLK_DATA(clk_data),
    .CURX(curx), .CURY(cury), .HBLANK(hblank), .VBLANK(vblank),
    .FRAME_TICK(frame_tick), .hs_vga(hs_vga), .vs_vga(vs_vga),
    .RED(red), .GREEN(green), .BLUE(blue)
  );
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, x);
    end
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_clk_data"}, 32'(clk_data), 0);
    chk({tag, "_curx"}, 32'(curx), 0);
    chk({tag, "_cury"}, 32'(cury), 0);
    chk({tag, "_blank"}, 32'({hblank, vblank}), 0);
    chk({tag, "_frame_tick"}, 32'(frame_tick), 0);
    chk({tag, "_syncs"}, 32'({hs_vga, vs_vga}), 3);
    chk({tag, "_rgb"}, 32'({red, green, blue}), 0);
  endtask
  // State after pixel tick n (ticks counted from 1 after reset release).
  function automatic exp_t model(input int n);
    exp_t x;
    int p, h, v, q, hq, vq;
    p = n % FT;
    h = p % HT;
    v = p / HT;
    x.n = n;
    x.curx = h < HV ? 10'(h) : 10'd0;
    x.cury = v < VV ? 9'(v) : 9'd0;
    x.hb = h >= HV;
    x.vb = v >= VV;
    x.ft = p == 0 && n > 0;
    x.hs = 1'b1;
    x.vs = 1'b1;
    x.rgb = 8'h00;
    if (n >= 2) begin
      q = (n - 2) % FT;
      hq = q % HT;
      vq = q / HT;
      x.hs = !(hq >= HV + HF && hq < HV + HF + HS);
      x.vs = !(vq >= VV + VF && vq < VV + VF + VS);
      x.rgb = (hq < HV && vq < VV) ? 8'(hq) : 8'h00;
    end
    return x;
  endfunction
  task automatic run_edges(input int cnt);
    repeat (cnt) begin
      @(posedge clk);
      e++;
      if (e % 2 == 0) sb.push_back(model(e / 2));
    end
  endtask
  // Consumer stage: registers CURX[7:0] as COLOR one pixel tick later.
  initial begin
    logic [7:0] prev;
    logic pcd;
    prev = 8'h00;
    pcd = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 8'h00;
        pcd = 1'b0;
        color = 8'h00;
      end else begin
        if (pcd && !clk_data) begin
          color = prev;
          prev = curx[7:0];
        end
        pcd = clk_data;
      end
    end
  end
  // Monitor: a falling CLK_DATA marks a pixel tick at the preceding edge.
  initial begin
    exp_t x, act;
    logic pcd;
    pcd = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) pcd = 1'b0;
      else begin
        if (pcd && !clk_data) begin
          if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_tick actual=tick required=none");
          end else begin
            x = sb.pop_front();
            act.n = x.n;
            act.curx = curx;
            act.cury = cury;
            act.hb = hblank;
            act.vb = vblank;
            act.hs = hs_vga;
            act.vs = vs_vga;
            act.ft = frame_tick;
            act.rgb = {red, green, blue};
            checks++;
            if (act !== x) begin
              fails++;
              $display("FAIL tick n=%0d actual=%h required=%h", x.n, act, x);
            end
            if (frame_tick) ft_seen++;
            for (int i = 0; i < 8; i++)
              if (x.n == spot_n[i]) chk($sformatf("spot_n%0d", x.n), 32'({hs_vga, red, green, blue}), 32'({spot_hs[i], spot_rgb[i]}));
          end
        end else chk("frame_tick_idle", 32'(frame_tick), 0);
        pcd = clk_data;
      end
    end
  end
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
  // Sync and frame-tick timing in clk_50MHz cycles since reset release.
  initial begin
    int hs_fall, vs_fall, ft_last;
    logic hs_p, vs_p;
    hs_fall = -1;
    vs_fall = -1;
    ft_last = -1;
    hs_p = 1'b1;
    vs_p = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        hs_fall = -1;
        vs_fall = -1;
        ft_last = -1;
        hs_p = 1'b1;
        vs_p = 1'b1;
      end else begin
        if (hs_p && !hs_vga) begin
          if (hs_fall < 0) chk("hs_first_fall", cyc, 1316);
          else chk("hs_period", cyc - hs_fall, 1600);
          hs_fall = cyc;
        end
        if (!hs_p && hs_vga && hs_fall >= 0) chk("hs_width", cyc - hs_fall, 192);
        if (vs_p && !vs_vga) begin
          if (vs_fall < 0) chk("vs_first_fall", cyc, 12804);
          else chk("vs_period", cyc - vs_fall, 19200);
          vs_fall = cyc;
        end
        if (!vs_p && vs_vga && vs_fall >= 0) chk("vs_width", cyc - vs_fall, 3200);
        if (frame_tick) begin
          if (ft_last < 0) chk("ft_first", cyc, 19200);
          else chk("ft_period", cyc - ft_last, 19200);
          ft_last = cyc;
        end
        hs_p = hs_vga;
        vs_p = vs_vga;
      end
    end
  end
  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    check_reset("por");
    rst = 1'b0;
    e = 0;
    run_edges(2 * FT + 2 * (3 * HT + 700));
    @(negedge clk);
    #2;
    chk("pre_rst_cury", 32'(cury), 3);
    chk("pre_rst_hblank", 32'(hblank), 1);
    rst = 1'b1;
    sb.delete();
    #1;
    check_reset("async");
    repeat (3) @(posedge clk);
    #1;
    check_reset("held");
    @(negedge clk);
    #2;
    rst = 1'b0;
    e = 0;
    run_edges(2 * FT + 400);
    @(negedge clk);
    #2;
    chk("sb_drained", sb.size(), 0);
    chk("frame_ticks", ft_seen, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
